main_memory: RTL and testbench
==============================

// Module: main_memory
// PURPOSE
//  Main-memory responder for cache miss traffic; the far end of the instruction_cache and data-cache miss interfaces.
//  Accepts line requests (icache read-only; dcache read or write-back), arbitrates with dcache priority plus anti-starvation aging,
//  and emulates fixed memory latency. Returns one full line per read. Instantiated in core_wrapper beside both caches.
// PARAMETERS
//  ADDR_WIDTH    32    byte-address width of miss requests
//  LINE_WIDTH    128   cache line width in bits (icache and dcache lines are identical)
//  MEM_LINES     4096  memory depth in lines; power of two
//  MEM_LATENCY   10    cycles from accept to response; legal range 1..255
//  INIT_FILE     ""    $readmemh image loaded at time 0; empty string means no load (contents X)
// PORTS
//  clock               in   1           system clock
//  reset               in   1           asynchronous reset, active-low
//  icache_req_valid    in   1           icache miss request; held high until icache_rsp_valid
//  icache_req_addr     in   ADDR_WIDTH  byte address of missing line
//  icache_rsp_valid    out  1           one-cycle pulse: icache_rsp_data valid
//  icache_rsp_data     out  LINE_WIDTH  requested line
//  dcache_req_valid    in   1           dcache request; held high until dcache_rsp_valid
//  dcache_req_addr     in   ADDR_WIDTH  byte address of line
//  dcache_req_is_write in   1           1 = write-back of dcache_req_wr_data; 0 = line read
//  dcache_req_wr_data  in   LINE_WIDTH  eviction data (used only when is_write)
//  dcache_rsp_valid    out  1           one-cycle pulse: read data valid or write completed
//  dcache_rsp_data     out  LINE_WIDTH  read line; all-zero on write completion
//  mem_busy            out  1           1 while state != IDLE
// BEHAVIOUR
//  - Reset (async, reset low): state=IDLE, counter=0, age=0, mask=0; all rsp_valid=0, rsp_data=0, mem_busy=0.
//    Memory array is NOT reset. Reset asserted mid-transaction aborts it; no response is ever issued for it.
//  - Line index = addr[log2(LINE_WIDTH/8) +: log2(MEM_LINES)]; low offset bits ignored; upper bits ignored (wrap modulo MEM_LINES).
//  - FSM IDLE -> BUSY -> RESP -> IDLE:
//    IDLE: grant on any unmasked valid; latch port id, line index, is_write, wr_data; counter=1; -> BUSY.
//    BUSY: counter++ each cycle; when counter==MEM_LATENCY -> RESP.
//    RESP: write: array[idx] <= wr_data. Read: drive rsp_data=array[idx]. Pulse granted port's rsp_valid; -> IDLE.
//  - Latency: request accepted in IDLE at cycle T -> rsp_valid high in cycle T+MEM_LATENCY+1 (MEM_LATENCY=1: T+2).
//  - Requests are latched at accept; input changes after accept are ignored.
//  - Arbitration: both valid -> dcache wins, unless age=1 -> icache wins. age<=1 when icache was valid but lost; age<=0 on icache grant.
//  - Mask: the port served in RESP is masked for the following IDLE cycle, so its still-high valid is not re-accepted.
//    The other port may be granted in that cycle.
//  - One outstanding transaction total; no pipelining. Requests are served strictly one at a time, so write-then-read
//    to the same line always returns the new data.
//  - rsp_data holds its last value when rsp_valid=0; consumers use it only when rsp_valid=1.
//  - Counter width $clog2(MEM_LATENCY+1); never wraps, because the FSM leaves BUSY at MEM_LATENCY.
// STRUCTURE
//  - soc.vh: MAIN_MEMORY_LATENCY, MAIN_MEMORY_LAT_LOG, MAIN_MEMORY_LINES, ICACHE_LINE_WIDTH (=DCACHE_LINE_WIDTH),
//    ICACHE_ADDR_WIDTH; typedef enum {MEM_IDLE, MEM_BUSY, MEM_RESP} mem_state_t; typedef enum {PORT_IC, PORT_DC} mem_port_t.
//  - Sub-module mem_arbiter: 2-way fixed priority with age bit and per-port mask.
//    Inputs: valids, mask, grant_en. Outputs: grant onehot, age. Holds the age flop.
//  - Top: FSM, latency counter, request latch, array (behavioural reg array, synchronous write in RESP), output regs.
//    All flops via RST_FF / RST_EN_FF.
// TESTING
//  1. Preload array[5]=0xA5..A5; icache read addr 0x50; MEM_LATENCY=10 -> icache_rsp_valid one pulse at T+11, data 0xA5..A5.
//  2. dcache write 0x1234 to addr 0x200, then dcache read 0x200 -> write rsp at T+11 with data 0;
//     read rsp returns 0x1234 after the 1-cycle mask bubble.
//  3. Both valid same cycle -> dcache served first; icache next, even if dcache re-requests immediately (age).
//     Back-to-back dcache reads never starve icache.
//  4. Requester holds valid through rsp -> exactly one rsp_valid per request; no duplicate accept.
//  5. Assert reset in BUSY at counter=4 -> outputs zero immediately; no rsp_valid after release;
//     a new request completes with full latency.
//  6. Addr 0x0001_0050 with MEM_LINES=4096 -> aliases line 5; MEM_LATENCY=1 -> rsp at T+2.

Source files
------------

// File: rtl/main_memory_pkg.sv
// Shared types and default sizing for the main-memory miss responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package main_memory_pkg;

    localparam int MM_ADDR_WIDTH = 32;
    localparam int MM_LINE_WIDTH = 128;
    localparam int MM_LINES      = 4096;
    localparam int MM_LATENCY    = 10;

    // Bit positions of each requester in the two-bit valid/mask/grant vectors
    localparam int PORT_IC_BIT = 0;
    localparam int PORT_DC_BIT = 1;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_t;

    typedef enum logic {
        PORT_IC = 1'b0,
        PORT_DC = 1'b1
    } mem_port_t;

    // One-hot mask covering the given requester
    function automatic logic [1:0] port_onehot(input mem_port_t p);
        return (p == PORT_DC) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/main_memory_arbiter.sv
// Two-way requester arbiter: dcache priority, icache wins when its age bit is set.
// Latency: combinational grant; age flop updates on the granting edge.
// Backpressure: grants only while grant_en_i is high; masked requesters are ignored.
// Ports: valid_i/mask_i (bit0 icache, bit1 dcache), grant_en_i, grant_o one-hot, age_o.
module main_memory_arbiter
    import main_memory_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] valid_i,
    input  logic [1:0] mask_i,
    input  logic       grant_en_i,
    output logic [1:0] grant_o,
    output logic       age_o
);

    logic       age_q, age_d;
    logic [1:0] eligible;

    assign eligible = valid_i & ~mask_i;
    assign age_o    = age_q;

    always_comb begin
        grant_o = 2'b00;
        age_d   = age_q;
        if (grant_en_i) begin
            if (eligible[PORT_DC_BIT] && !(eligible[PORT_IC_BIT] && age_q)) begin
                grant_o[PORT_DC_BIT] = 1'b1;
            end else if (eligible[PORT_IC_BIT]) begin
                grant_o[PORT_IC_BIT] = 1'b1;
            end
            // An icache that asked and lost gets priority at the next contest
            if (grant_o[PORT_IC_BIT]) begin
                age_d = 1'b0;
            end else if (eligible[PORT_IC_BIT]) begin
                age_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            age_q <= 1'b0;
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/main_memory.sv
// Main-memory responder for icache/dcache line misses; one transaction at a time.
// Latency: accept in IDLE at cycle T -> rsp_valid pulse at T+MEM_LATENCY+1.
// Backpressure: requesters hold valid until their rsp_valid; a served port is masked for one IDLE cycle.
// Ports: clock/reset (async active-low); icache_req_* / icache_rsp_*; dcache_req_* / dcache_rsp_*; mem_busy.
module main_memory
    import main_memory_pkg::*;
#(
    parameter int ADDR_WIDTH  = MM_ADDR_WIDTH,
    parameter int LINE_WIDTH  = MM_LINE_WIDTH,
    parameter int MEM_LINES   = MM_LINES,
    parameter int MEM_LATENCY = MM_LATENCY
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  icache_req_valid,
    input  logic [ADDR_WIDTH-1:0] icache_req_addr,
    output logic                  icache_rsp_valid,
    output logic [LINE_WIDTH-1:0] icache_rsp_data,
    input  logic                  dcache_req_valid,
    input  logic [ADDR_WIDTH-1:0] dcache_req_addr,
    input  logic                  dcache_req_is_write,
    input  logic [LINE_WIDTH-1:0] dcache_req_wr_data,
    output logic                  dcache_rsp_valid,
    output logic [LINE_WIDTH-1:0] dcache_rsp_data,
    output logic                  mem_busy
);

    localparam int OFF_W = $clog2(LINE_WIDTH / 8);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY);

    mem_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             mask_q, mask_d;
    mem_port_t              port_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   is_wr_q;
    logic [LINE_WIDTH-1:0]  wr_dat_q;
    logic                   ic_vld_q, dc_vld_q;
    logic [LINE_WIDTH-1:0]  ic_dat_q, dc_dat_q;
    logic [LINE_WIDTH-1:0]  mem_q [MEM_LINES];

    logic [1:0]             grant;
    logic                   grant_en;
    logic                   accept;
    logic                   rsp_fire;
    logic                   unused_age;
    logic                   unused_addr_bits;

    // Offset and upper address bits are deliberately dropped; the index wraps modulo MEM_LINES
    assign unused_addr_bits = ^{icache_req_addr, dcache_req_addr};

    main_memory_arbiter u_arb (
        .clock      (clock),
        .reset      (reset),
        .valid_i    ({dcache_req_valid, icache_req_valid}),
        .mask_i     (mask_q),
        .grant_en_i (grant_en),
        .grant_o    (grant),
        .age_o      (unused_age)
    );

    assign grant_en = (state_q == MEM_IDLE);
    assign accept   = grant_en && (grant != 2'b00);
    // Output registers load on the BUSY->RESP edge so the pulse lands in the RESP cycle
    assign rsp_fire = (state_q == MEM_BUSY) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        unique case (state_q)
            MEM_IDLE: begin
                mask_d = 2'b00;
                if (accept) begin
                    state_d = MEM_BUSY;
                    cnt_d   = CNT_W'(1);
                end
            end
            MEM_BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = MEM_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MEM_RESP: begin
                state_d = MEM_IDLE;
                cnt_d   = '0;
                mask_d  = port_onehot(port_q);
            end
            default: begin
                state_d = MEM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= MEM_IDLE;
            cnt_q    <= '0;
            mask_q   <= '0;
            port_q   <= PORT_IC;
            idx_q    <= '0;
            is_wr_q  <= 1'b0;
            wr_dat_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            if (accept) begin
                port_q   <= grant[PORT_DC_BIT] ? PORT_DC : PORT_IC;
                idx_q    <= grant[PORT_DC_BIT] ? dcache_req_addr[OFF_W +: IDX_W]
                                               : icache_req_addr[OFF_W +: IDX_W];
                is_wr_q  <= grant[PORT_DC_BIT] & dcache_req_is_write;
                wr_dat_q <= dcache_req_wr_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ic_vld_q <= 1'b0;
            dc_vld_q <= 1'b0;
            ic_dat_q <= '0;
            dc_dat_q <= '0;
        end else begin
            ic_vld_q <= rsp_fire && (port_q == PORT_IC);
            dc_vld_q <= rsp_fire && (port_q == PORT_DC);
            if (rsp_fire && (port_q == PORT_IC)) begin
                ic_dat_q <= mem_q[idx_q];
            end
            if (rsp_fire && (port_q == PORT_DC)) begin
                dc_dat_q <= is_wr_q ? '0 : mem_q[idx_q];
            end
        end
    end

    // Storage is not reset; an aborted write never reaches RESP and so never lands
    always_ff @(posedge clock) begin
        if ((state_q == MEM_RESP) && is_wr_q) begin
            mem_q[idx_q] <= wr_dat_q;
        end
    end

    assign icache_rsp_valid = ic_vld_q;
    assign icache_rsp_data  = ic_dat_q;
    assign dcache_rsp_valid = dc_vld_q;
    assign dcache_rsp_data  = dc_dat_q;
    assign mem_busy         = (state_q != MEM_IDLE);

endmodule

// File: tb/tb_main_memory.sv
module tb_main_memory;

    localparam int LAT  = 10;
    localparam int LAT1 = 1;

    typedef struct {
        logic [127:0] data;
        int           cyc;
    } exp_t;

    logic         clock;
    logic         reset;
    logic         icache_req_valid;
    logic [31:0]  icache_req_addr;
    logic         icache_rsp_valid;
    logic [127:0] icache_rsp_data;
    logic         dcache_req_valid;
    logic [31:0]  dcache_req_addr;
    logic         dcache_req_is_write;
    logic [127:0] dcache_req_wr_data;
    logic         dcache_rsp_valid;
    logic [127:0] dcache_rsp_data;
    logic         mem_busy;

    logic         u1_ic_vld, u1_ic_rsp_vld, u1_dc_vld, u1_dc_wr, u1_dc_rsp_vld, u1_busy;
    logic [31:0]  u1_ic_addr, u1_dc_addr;
    logic [127:0] u1_ic_rsp_dat, u1_dc_wdat, u1_dc_rsp_dat;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int ic_pulses = 0;
    int last_ic_cyc = 0;
    int last_dc_cyc = 0;
    exp_t exp_ic[$];
    exp_t exp_dc[$];
    exp_t mon_ic, mon_dc;
    logic [127:0] mdl [4096];

    main_memory #(.ADDR_WIDTH(32), .LINE_WIDTH(128), .MEM_LINES(4096), .MEM_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
        .icache_rsp_valid(icache_rsp_valid), .icache_rsp_data(icache_rsp_data),
        .dcache_req_valid(dcache_req_valid), .dcache_req_addr(dcache_req_addr),
        .dcache_req_is_write(dcache_req_is_write), .dcache_req_wr_data(dcache_req_wr_data),
        .dcache_rsp_valid(dcache_rsp_valid), .dcache_rsp_data(dcache_rsp_data),
        .mem_busy(mem_busy)
    );

    main_memory #(.ADDR_WIDTH(32), .LINE_WIDTH(128), .MEM_LINES(16), .MEM_LATENCY(LAT1)) dut1 (
        .clock(clock), .reset(reset),
        .icache_req_valid(u1_ic_vld), .icache_req_addr(u1_ic_addr),
        .icache_rsp_valid(u1_ic_rsp_vld), .icache_rsp_data(u1_ic_rsp_dat),
        .dcache_req_valid(u1_dc_vld), .dcache_req_addr(u1_dc_addr),
        .dcache_req_is_write(u1_dc_wr), .dcache_req_wr_data(u1_dc_wdat),
        .dcache_rsp_valid(u1_dc_rsp_vld), .dcache_rsp_data(u1_dc_rsp_dat),
        .mem_busy(u1_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int line_of(input logic [31:0] addr, input int lines);
        return int'((addr >> 4) % lines);
    endfunction

    // Random offset and random upper bits around a given line index
    function automatic logic [31:0] mk_addr(input int line);
        logic [31:0] a;
        a = ($urandom & 32'hFFFF_0000) | (32'(line) << 4) | ($urandom & 32'h0000_000F);
        return a;
    endfunction

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard monitor: pops one expectation per response pulse
    always @(negedge clock) begin
        if (icache_rsp_valid) begin
            ic_pulses++;
            last_ic_cyc = cyc;
            if (exp_ic.size() == 0) begin
                check("ic_unexpected_rsp", 128'd1, 128'd0);
            end else begin
                mon_ic = exp_ic.pop_front();
                check("ic_data", icache_rsp_data, mon_ic.data);
                if (mon_ic.cyc >= 0) check("ic_cycle", 128'(cyc), 128'(mon_ic.cyc));
            end
        end
        if (dcache_rsp_valid) begin
            last_dc_cyc = cyc;
            if (exp_dc.size() == 0) begin
                check("dc_unexpected_rsp", 128'd1, 128'd0);
            end else begin
                mon_dc = exp_dc.pop_front();
                check("dc_data", dcache_rsp_data, mon_dc.data);
                if (mon_dc.cyc >= 0) check("dc_cycle", 128'(cyc), 128'(mon_dc.cyc));
            end
        end
    end

    // Called just after a rising edge; holds valid through the post-response idle cycle
    task automatic ic_req(input logic [31:0] addr, input int exp_cyc, input bit scramble);
        exp_t e;
        int n;
        e.data = mdl[line_of(addr, 4096)];
        e.cyc  = exp_cyc;
        exp_ic.push_back(e);
        icache_req_addr  = addr;
        icache_req_valid = 1'b1;
        if (scramble) begin
            @(posedge clock); #1;
            icache_req_addr = $urandom;
        end
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!icache_rsp_valid && n < 400);
        check("ic_rsp_arrived", 128'(icache_rsp_valid), 128'd1);
        @(posedge clock);
        @(posedge clock); #1;
        icache_req_valid = 1'b0;
    endtask

    task automatic dc_req(input logic [31:0] addr, input bit wr, input logic [127:0] wdat,
                          input int exp_cyc, input bit scramble);
        exp_t e;
        int n;
        if (wr) begin
            e.data = '0;
            mdl[line_of(addr, 4096)] = wdat;
        end else begin
            e.data = mdl[line_of(addr, 4096)];
        end
        e.cyc = exp_cyc;
        exp_dc.push_back(e);
        dcache_req_addr     = addr;
        dcache_req_is_write = wr;
        dcache_req_wr_data  = wdat;
        dcache_req_valid    = 1'b1;
        if (scramble) begin
            @(posedge clock); #1;
            dcache_req_addr     = $urandom;
            dcache_req_is_write = $urandom;
            dcache_req_wr_data  = rnd_line();
        end
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!dcache_rsp_valid && n < 400);
        check("dc_rsp_arrived", 128'(dcache_rsp_valid), 128'd1);
        @(posedge clock);
        @(posedge clock); #1;
        dcache_req_valid = 1'b0;
    endtask

    // Directed transaction on the latency-1, 16-line instance: response exactly two cycles after issue
    task automatic u1_txn(input bit is_ic, input bit wr, input logic [31:0] addr,
                          input logic [127:0] wdat, input logic [127:0] edat);
        if (is_ic) begin
            u1_ic_addr = addr;
            u1_ic_vld  = 1'b1;
        end else begin
            u1_dc_addr = addr;
            u1_dc_wr   = wr;
            u1_dc_wdat = wdat;
            u1_dc_vld  = 1'b1;
        end
        @(negedge clock);
        @(negedge clock);
        check("l1_rsp_early", 128'(is_ic ? u1_ic_rsp_vld : u1_dc_rsp_vld), 128'd0);
        @(negedge clock);
        check("l1_rsp_valid", 128'(is_ic ? u1_ic_rsp_vld : u1_dc_rsp_vld), 128'd1);
        check("l1_rsp_data", is_ic ? u1_ic_rsp_dat : u1_dc_rsp_dat, edat);
        @(posedge clock);
        @(posedge clock); #1;
        u1_ic_vld = 1'b0;
        u1_dc_vld = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   128'(mem_busy), 128'd0);
        check({tag, "_ic_vld"}, 128'(icache_rsp_valid), 128'd0);
        check({tag, "_dc_vld"}, 128'(dcache_rsp_valid), 128'd0);
        check({tag, "_ic_dat"}, icache_rsp_data, 128'd0);
        check({tag, "_dc_dat"}, dcache_rsp_data, 128'd0);
    endtask

    initial begin
        int k;
        int pulses_before;
        logic [127:0] d;

        reset = 1'b0;
        icache_req_valid = 1'b0; icache_req_addr = '0;
        dcache_req_valid = 1'b0; dcache_req_addr = '0;
        dcache_req_is_write = 1'b0; dcache_req_wr_data = '0;
        u1_ic_vld = 1'b0; u1_ic_addr = '0;
        u1_dc_vld = 1'b0; u1_dc_addr = '0; u1_dc_wr = 1'b0; u1_dc_wdat = '0;

        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(posedge clock); #1;

        // Preload lines 0..47 through the write-back path; line 5 gets the A5 pattern
        for (int i = 0; i < 48; i++) begin
            d = (i == 5) ? {16{8'hA5}} : rnd_line();
            dc_req(mk_addr(i), 1'b1, d, cyc + LAT + 1, 1'b1);
        end

        // Plain icache read, then an aliased address of the same line
        ic_req(32'h0000_0050, cyc + LAT + 1, 1'b1);
        ic_req(32'h0001_0050, cyc + LAT + 1, 1'b0);

        // Write-back followed by read of the same line
        dc_req(32'h0000_0200, 1'b1, 128'h1234, cyc + LAT + 1, 1'b0);
        dc_req(32'h0000_0200, 1'b0, '0, cyc + LAT + 1, 1'b0);

        // Simultaneous requests: dcache first, icache after one idle turnaround
        k = cyc;
        fork
            dc_req(mk_addr(40), 1'b0, '0, k + LAT + 1, 1'b0);
            ic_req(mk_addr(3), k + 2 * LAT + 3, 1'b0);
        join
        check("order_dc_first", 128'(last_dc_cyc < last_ic_cyc), 128'd1);

        // Back-to-back dcache reads must not starve a waiting icache request
        k = cyc;
        fork
            begin
                for (int i = 0; i < 3; i++) dc_req(mk_addr(41 + i), 1'b0, '0, -1, 1'b0);
            end
            begin
                repeat (3) begin @(posedge clock); #1; end
                ic_req(mk_addr(4), k + 2 * LAT + 3, 1'b0);
            end
        join

        // Random concurrent traffic on disjoint line ranges
        fork
            begin
                repeat (20) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
                    ic_req(mk_addr($urandom_range(0, 31)), -1, 1'b0);
                end
            end
            begin
                repeat (20) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
                    dc_req(mk_addr($urandom_range(33, 47)), 1'($urandom_range(0, 1)), rnd_line(), -1, 1'b0);
                end
            end
        join

        // Reset in the middle of a transaction aborts it without a response
        icache_req_addr  = mk_addr(6);
        icache_req_valid = 1'b1;
        repeat (5) @(negedge clock);
        check("busy_before_reset", 128'(mem_busy), 128'd1);
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        icache_req_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        pulses_before = ic_pulses;
        repeat (30) @(negedge clock);
        check("no_rsp_after_abort", 128'(ic_pulses), 128'(pulses_before));
        @(posedge clock); #1;
        ic_req(mk_addr(5), cyc + LAT + 1, 1'b0);

        repeat (5) @(posedge clock);
        #1;
        check("ic_queue_drained", 128'(exp_ic.size()), 128'd0);
        check("dc_queue_drained", 128'(exp_dc.size()), 128'd0);

        // Latency-1 instance with 16 lines: T+2 response and modulo-16 aliasing
        d = rnd_line();
        u1_txn(1'b0, 1'b1, 32'h0000_0050, d, 128'd0);
        u1_txn(1'b0, 1'b0, 32'h0001_0150, '0, d);
        u1_txn(1'b1, 1'b0, 32'h0000_0F50, '0, d);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
